// File: rtl/osc_pair_cmp.sv
// Ring-oscillator pair comparator: times a counting window per pair, compares the frozen counts
// and assembles a C_NBITS PUF response. Optional PUF_MARGIN_MASK_EN adds an O_mask reliability word.
module osc_pair_cmp #(
  parameter int C_DWIDTH = 24,
  parameter int C_WINDOW = 4096,
  parameter int C_SETTLE = 4,
  parameter int C_NBITS  = 32,
  parameter int C_SELW   = 5,
  parameter int C_MARGIN = 16
) (
  input  logic                I_clk,
  input  logic                I_rst,
  input  logic                I_start,
  input  logic [C_DWIDTH-1:0] I_count_a,
  input  logic [C_DWIDTH-1:0] I_count_b,
  output logic                O_osc_rst_n,
  output logic [C_SELW-1:0]   O_sel,
  output logic                O_busy,
  output logic [C_NBITS-1:0]  O_resp,
  output logic                O_valid,
  input  logic                I_ready
`ifdef PUF_MARGIN_MASK_EN
  ,output logic [C_NBITS-1:0] O_mask
`endif
);

  typedef enum logic [2:0] {IDLE, RUN, SETTLE, CMP, DONE} state_t;

  localparam int CMAX = (C_WINDOW > C_SETTLE) ? C_WINDOW : C_SETTLE;
  localparam int CW   = $clog2(CMAX);

  state_t              state, nxt;
  logic [CW-1:0]       cnt;
  logic [C_DWIDTH-1:0] a_q, b_q;
  logic                win_last, set_last, sel_last;
  logic                accept, sample, fire, bit_val;

  assign win_last = (cnt == CW'(C_WINDOW - 1));
  assign set_last = (cnt == CW'(C_SETTLE - 1));
  assign sel_last = (O_sel == C_SELW'(C_NBITS - 1));

  always_ff @(posedge I_clk or negedge I_rst)
    if (!I_rst) state <= IDLE;
    else        state <= nxt;

  // IDLE with busy already set is the one-cycle arm slot between start accept and the first window.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (O_busy)   nxt = RUN;
      RUN:     if (win_last) nxt = SETTLE;
      SETTLE:  if (set_last) nxt = CMP;
      CMP:     nxt = sel_last ? DONE : RUN;
      DONE:    if (I_ready)  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    accept  = 1'b0;
    sample  = 1'b0;
    fire    = 1'b0;
    bit_val = 1'b0;
    case (state)
      IDLE:    accept = I_start && !O_busy;
      SETTLE:  sample = set_last;
      CMP:     begin fire = 1'b1; bit_val = (a_q > b_q); end
      default: ;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      O_osc_rst_n <= 1'b0;
      O_sel       <= '0;
      O_busy      <= 1'b0;
      O_resp      <= '0;
      O_valid     <= 1'b0;
    end else begin
      if (nxt != state)                       cnt <= '0;
      else if (state == RUN || state == SETTLE) cnt <= cnt + CW'(1);
      O_osc_rst_n <= (nxt == RUN);
      O_valid     <= (nxt == DONE);
      if (accept)           O_busy <= 1'b1;
      else if (nxt == DONE) O_busy <= 1'b0;
      if (sample) begin
        a_q <= I_count_a;
        b_q <= I_count_b;
      end
      if (accept) begin
        O_sel  <= '0;
        O_resp <= '0;
      end else if (fire) begin
        for (int i = 0; i < C_NBITS; i++)
          if (O_sel == C_SELW'(i)) O_resp[i] <= bit_val;
        // Select moves while both counters are still held in reset.
        if (!sel_last) O_sel <= O_sel + C_SELW'(1);
      end
    end
  end

`ifdef PUF_MARGIN_MASK_EN
  logic [C_DWIDTH-1:0] diff;
  assign diff = (a_q > b_q) ? (a_q - b_q) : (b_q - a_q);

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) O_mask <= '0;
    else if (accept) O_mask <= '0;
    else if (fire) begin
      for (int i = 0; i < C_NBITS; i++)
        if (O_sel == C_SELW'(i)) O_mask[i] <= (diff < C_DWIDTH'(C_MARGIN));
    end
  end
`endif

endmodule

// File: tb/tb_osc_pair_cmp.sv
// Randomized bench for osc_pair_cmp against a per-pair compare model; covers reset, latency,
// window length, select stepping, handshake hold and ignored starts.
module tb_osc_pair_cmp;
  localparam int W = 16, S = 2, N = 4, DW = 8, SW = 2, M = 4;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, ready = 1'b0;
  logic [DW-1:0] cnt_a, cnt_b;
  logic          osc_rst_n, busy, valid;
  logic [SW-1:0] sel;
  logic [N-1:0]  resp;
`ifdef PUF_MARGIN_MASK_EN
  logic [N-1:0]  mask;
`endif
  logic [DW-1:0] tbl_a [N];
  logic [DW-1:0] tbl_b [N];
  int            tests = 0, fails = 0;

  always #5 clk = ~clk;

  // Oscillator array model: pair select picks the counts that A and B report.
  assign cnt_a = tbl_a[sel];
  assign cnt_b = tbl_b[sel];

  osc_pair_cmp #(.C_DWIDTH(DW), .C_WINDOW(W), .C_SETTLE(S), .C_NBITS(N), .C_SELW(SW),
                 .C_MARGIN(M)) dut (
    .I_clk(clk), .I_rst(rst_n), .I_start(start), .I_count_a(cnt_a), .I_count_b(cnt_b),
    .O_osc_rst_n(osc_rst_n), .O_sel(sel), .O_busy(busy), .O_resp(resp), .O_valid(valid),
    .I_ready(ready)
`ifdef PUF_MARGIN_MASK_EN
    ,.O_mask(mask)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_resp();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (int'(tbl_a[i]) > int'(tbl_b[i]));
    return r;
  endfunction

  function automatic logic [N-1:0] exp_mask();
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) begin
      int d = int'(tbl_a[i]) - int'(tbl_b[i]);
      if (d < 0) d = -d;
      m[i] = (d < M);
    end
    return m;
  endfunction

  task automatic load(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
    for (int i = 0; i < N; i++) begin
      tbl_a[i] = a[i*DW +: DW];
      tbl_b[i] = b[i*DW +: DW];
    end
  endtask

  task automatic run(input string tag, input bit poke);
    int cyc = 0, hi = 0, nwin = 0, sel_bad = 0, win_bad = 0;
    bit prev = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk({tag, ".busy_on"}, 32'(busy), 32'd1);
    while (!valid && cyc < 400) begin
      start = poke && (cyc == 6 || cyc == 40);
      @(posedge clk); #1; cyc++;
      if (osc_rst_n) begin
        hi++;
        if (int'(sel) != nwin) sel_bad++;
      end else if (prev) begin
        if (hi != W) win_bad++;
        nwin++;
        hi = 0;
      end
      prev = osc_rst_n;
    end
    start = 1'b0;
    chk({tag, ".latency"}, 32'(cyc), 32'(N*(W+S+1)+1));
    chk({tag, ".windows"}, 32'(nwin), 32'(N));
    chk({tag, ".win_len_bad"}, 32'(win_bad), 32'd0);
    chk({tag, ".sel_bad"}, 32'(sel_bad), 32'd0);
    chk({tag, ".busy_off"}, 32'(busy), 32'd0);
    chk({tag, ".resp"}, 32'(resp), 32'(exp_resp()));
`ifdef PUF_MARGIN_MASK_EN
    chk({tag, ".mask"}, 32'(mask), 32'(exp_mask()));
`endif
  endtask

  task automatic hs(input string tag, input int hold, input bit start_too);
    logic [N-1:0] r0 = resp;
    int bad = 0;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!valid || resp !== r0 || busy) bad++;
    end
    chk({tag, ".hold"}, 32'(bad), 32'd0);
    ready = 1'b1; start = start_too;
    @(posedge clk); #1; ready = 1'b0; start = 1'b0;
    chk({tag, ".valid_off"}, 32'(valid), 32'd0);
    chk({tag, ".resp_kept"}, 32'(resp), 32'(r0));
    @(posedge clk); #1;
    chk({tag, ".no_start"}, 32'(busy), 32'd0);
  endtask

  initial begin
    load('0, '0);
    repeat (3) @(posedge clk); #1;
    chk("rst.osc", 32'(osc_rst_n), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.valid", 32'(valid), 32'd0);
    chk("rst.resp", 32'(resp), 32'd0);
    chk("rst.sel", 32'(sel), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    load({8'd200, 8'd50, 8'd80, 8'd100}, {8'd10, 8'd50, 8'd95, 8'd90});
    run("basic", 1'b0);
    chk("basic.word", 32'(resp), 32'b1001);
    hs("basic", 10, 1'b0);

    load({8'd0, 8'd0, 8'd255, 8'd255}, {8'd0, 8'd255, 8'd0, 8'd255});
    run("extreme", 1'b1);
    chk("extreme.word", 32'(resp), 32'b0010);
    hs("extreme", 2, 1'b1);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) begin
        int a = int'($urandom_range(0, 255));
        int d = int'($urandom_range(0, 6));
        int b = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 255))
                                            : ((a + d > 255) ? a - d : a + d);
        tbl_a[i] = 8'(a);
        tbl_b[i] = 8'(b);
      end
      run($sformatf("rnd%0d", k), k[0]);
      hs($sformatf("rnd%0d", k), int'($urandom_range(0, 3)), k[1]);
    end

`ifdef PUF_MARGIN_MASK_EN
    load({8'd200, 8'd50, 8'd80, 8'd100}, {8'd10, 8'd50, 8'd95, 8'd98});
    run("margin", 1'b0);
    chk("margin.word", 32'(resp), 32'b1001);
    chk("margin.maskword", 32'(mask), 32'b0101);
    hs("margin", 1, 1'b0);
`endif

    // Asynchronous reset while a response is pending
    load({8'd200, 8'd50, 8'd80, 8'd100}, {8'd10, 8'd50, 8'd95, 8'd90});
    run("pre_rst", 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_done.valid", 32'(valid), 32'd0);
    chk("rst_done.resp", 32'(resp), 32'd0);
    chk("rst_done.sel", 32'(sel), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Asynchronous reset in the middle of a window, then a clean rerun
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) @(posedge clk); #1;
    chk("rst_run.pre_osc", 32'(osc_rst_n), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_run.osc", 32'(osc_rst_n), 32'd0);
    chk("rst_run.busy", 32'(busy), 32'd0);
    chk("rst_run.valid", 32'(valid), 32'd0);
    chk("rst_run.resp", 32'(resp), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run("recover", 1'b0);
    hs("recover", 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
